// File: rtl/instr_decoder.sv
// Registered MIPS instruction decoder: latches the fetched word, decodes it into a
// one-hot instruction class plus register/immediate/jump fields, with a valid/ack handshake.
module instr_decoder #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr_in,
    input  logic               ir_in,
    input  logic               decode_ena,
    input  logic               ack,
    output logic [31:0]        ir,
    output logic [53:0]        decoded_instr,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [15:0]        imm16,
    output logic [25:0]        jidx,
    output logic               dec_valid,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic {EMPTY, HELD} state_t;
    state_t state;

    logic [31:0] src;
    logic [53:0] dec_next;

    // Bypass lets a fetch and its decode happen on the same edge.
    always_comb begin
        src = ir_in ? instr_in : ir;
    end

    always_comb begin
        dec_next = '0;
        case (src[31:26])
            6'h00: begin
                case (src[5:0])
                    6'h20: dec_next[0]  = 1'b1;
                    6'h21: dec_next[1]  = 1'b1;
                    6'h22: dec_next[2]  = 1'b1;
                    6'h23: dec_next[3]  = 1'b1;
                    6'h24: dec_next[4]  = 1'b1;
                    6'h25: dec_next[5]  = 1'b1;
                    6'h26: dec_next[6]  = 1'b1;
                    6'h27: dec_next[7]  = 1'b1;
                    6'h2A: dec_next[8]  = 1'b1;
                    6'h2B: dec_next[9]  = 1'b1;
                    6'h00: dec_next[10] = 1'b1;
                    6'h02: dec_next[11] = 1'b1;
                    6'h03: dec_next[12] = 1'b1;
                    6'h04: dec_next[13] = 1'b1;
                    6'h06: dec_next[14] = 1'b1;
                    6'h07: dec_next[15] = 1'b1;
                    6'h08: dec_next[16] = 1'b1;
                    6'h1B: dec_next[32] = 1'b1;
                    6'h09: dec_next[34] = 1'b1;
                    6'h10: dec_next[42] = 1'b1;
                    6'h12: dec_next[43] = 1'b1;
                    6'h11: dec_next[45] = 1'b1;
                    6'h13: dec_next[46] = 1'b1;
                    6'h19: dec_next[48] = 1'b1;
                    6'h0C: dec_next[49] = 1'b1;
                    6'h34: dec_next[50] = 1'b1;
                    6'h0D: dec_next[52] = 1'b1;
                    6'h1A: dec_next[53] = 1'b1;
                    default: ;
                endcase
            end
            6'h1C: begin
                if (src[5:0] == 6'h20) dec_next[31] = 1'b1;
                else if (src[5:0] == 6'h02) dec_next[47] = 1'b1;
            end
            6'h10: begin
                if (src[25:21] == 5'h00) dec_next[41] = 1'b1;
                else if (src[25:21] == 5'h04) dec_next[44] = 1'b1;
                else if (src[25:21] == 5'h10 && src[5:0] == 6'h18) dec_next[33] = 1'b1;
            end
            6'h01: if (src[20:16] == 5'h01) dec_next[51] = 1'b1;
            6'h08: dec_next[17] = 1'b1;
            6'h09: dec_next[18] = 1'b1;
            6'h0C: dec_next[19] = 1'b1;
            6'h0D: dec_next[20] = 1'b1;
            6'h0E: dec_next[21] = 1'b1;
            6'h23: dec_next[22] = 1'b1;
            6'h2B: dec_next[23] = 1'b1;
            6'h04: dec_next[24] = 1'b1;
            6'h05: dec_next[25] = 1'b1;
            6'h0A: dec_next[26] = 1'b1;
            6'h0B: dec_next[27] = 1'b1;
            6'h0F: dec_next[28] = 1'b1;
            6'h02: dec_next[29] = 1'b1;
            6'h03: dec_next[30] = 1'b1;
            6'h20: dec_next[35] = 1'b1;
            6'h24: dec_next[36] = 1'b1;
            6'h25: dec_next[37] = 1'b1;
            6'h28: dec_next[38] = 1'b1;
            6'h29: dec_next[39] = 1'b1;
            6'h21: dec_next[40] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            ir            <= '0;
            decoded_instr <= '0;
            rs            <= '0;
            rt            <= '0;
            rd            <= '0;
            shamt         <= '0;
            imm16         <= '0;
            jidx          <= '0;
            dec_valid     <= 1'b0;
            illegal       <= 1'b0;
            instr_count   <= '0;
        end else begin
            if (ir_in) ir <= instr_in;
            // A new decode takes precedence over a simultaneous ack.
            if (decode_ena) begin
                decoded_instr <= dec_next;
                rs            <= src[25:21];
                rt            <= src[20:16];
                rd            <= src[15:11];
                shamt         <= src[10:6];
                imm16         <= src[15:0];
                jidx          <= src[25:0];
                illegal       <= ~|dec_next;
                if (|dec_next) instr_count <= instr_count + COUNT_W'(1);
                state         <= HELD;
                dec_valid     <= 1'b1;
            end else if (state == HELD && ack) begin
                state     <= EMPTY;
                dec_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Bench for instr_decoder: directed steps plus randomized words checked against a
// mask/match rule-table reference model; a second instance exercises a 4-bit counter.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        rst, ir_in, decode_ena, ack;
    logic [31:0] instr_in;

    logic [31:0] ir_a, ir_b;
    logic [53:0] dec_a, dec_b;
    logic [4:0]  rs_a, rt_a, rd_a, sh_a, rs_b, rt_b, rd_b, sh_b;
    logic [15:0] imm_a, imm_b;
    logic [25:0] jidx_a, jidx_b;
    logic        val_a, val_b, ill_a, ill_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_decoder u_dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .ir_in(ir_in),
        .decode_ena(decode_ena), .ack(ack), .ir(ir_a), .decoded_instr(dec_a),
        .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a), .imm16(imm_a), .jidx(jidx_a),
        .dec_valid(val_a), .illegal(ill_a), .instr_count(cnt_a)
    );

    instr_decoder #(.COUNT_W(4)) u_w4 (
        .clk(clk), .rst(rst), .instr_in(instr_in), .ir_in(ir_in),
        .decode_ena(decode_ena), .ack(ack), .ir(ir_b), .decoded_instr(dec_b),
        .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b), .imm16(imm_b), .jidx(jidx_b),
        .dec_valid(val_b), .illegal(ill_b), .instr_count(cnt_b)
    );

    // Reference: each one-hot bit is an encoding described by (word & mask) == value.
    typedef struct {
        logic [31:0] mask;
        logic [31:0] val;
    } rule_t;
    rule_t rules[54];

    logic [31:0] m_ir;
    logic [53:0] m_dec;
    logic [31:0] m_src;
    logic        m_valid, m_ill;
    logic [31:0] m_cnt;

    task automatic build_rules();
        int unsigned rf[17] = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26,
                                32'h27, 32'h2A, 32'h2B, 32'h00, 32'h02, 32'h03, 32'h04,
                                32'h06, 32'h07, 32'h08};
        int unsigned io[14] = '{32'h08, 32'h09, 32'h0C, 32'h0D, 32'h0E, 32'h23, 32'h2B,
                                32'h04, 32'h05, 32'h0A, 32'h0B, 32'h0F, 32'h02, 32'h03};
        int unsigned ls[6]  = '{32'h20, 32'h24, 32'h25, 32'h28, 32'h29, 32'h21};
        for (int unsigned i = 0; i < 17; i++) rules[i] = '{32'hFC00003F, rf[i]};
        for (int unsigned i = 0; i < 14; i++) rules[17+i] = '{32'hFC000000, io[i] << 26};
        for (int unsigned i = 0; i < 6; i++)  rules[35+i] = '{32'hFC000000, ls[i] << 26};
        rules[31] = '{32'hFC00003F, 32'h70000020};
        rules[32] = '{32'hFC00003F, 32'h0000001B};
        rules[33] = '{32'hFFE0003F, 32'h42000018};
        rules[34] = '{32'hFC00003F, 32'h00000009};
        rules[41] = '{32'hFFE00000, 32'h40000000};
        rules[42] = '{32'hFC00003F, 32'h00000010};
        rules[43] = '{32'hFC00003F, 32'h00000012};
        rules[44] = '{32'hFFE00000, 32'h40800000};
        rules[45] = '{32'hFC00003F, 32'h00000011};
        rules[46] = '{32'hFC00003F, 32'h00000013};
        rules[47] = '{32'hFC00003F, 32'h70000002};
        rules[48] = '{32'hFC00003F, 32'h00000019};
        rules[49] = '{32'hFC00003F, 32'h0000000C};
        rules[50] = '{32'hFC00003F, 32'h00000034};
        rules[51] = '{32'hFC1F0000, 32'h04010000};
        rules[52] = '{32'hFC00003F, 32'h0000000D};
        rules[53] = '{32'hFC00003F, 32'h0000001A};
    endtask

    function automatic logic [53:0] ref_decode(input logic [31:0] w);
        logic [53:0] r = '0;
        for (int unsigned i = 0; i < 54; i++)
            if ((w & rules[i].mask) == rules[i].val) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [53:0] onehot(input int unsigned b);
        logic [53:0] r = '0;
        r[b] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ir", 64'(ir_a), 64'(m_ir));
        chk("decoded_instr", 64'(dec_a), 64'(m_dec));
        chk("rs", 64'(rs_a), 64'(m_src[25:21]));
        chk("rt", 64'(rt_a), 64'(m_src[20:16]));
        chk("rd", 64'(rd_a), 64'(m_src[15:11]));
        chk("shamt", 64'(sh_a), 64'(m_src[10:6]));
        chk("imm16", 64'(imm_a), 64'(m_src[15:0]));
        chk("jidx", 64'(jidx_a), 64'(m_src[25:0]));
        chk("dec_valid", 64'(val_a), 64'(m_valid));
        chk("illegal", 64'(ill_a), 64'(m_ill));
        chk("instr_count", 64'(cnt_a), 64'(m_cnt));
        chk("w4_count", 64'(cnt_b), 64'(m_cnt[3:0]));
        chk("w4_outputs", {ir_b, val_b, ill_b, rs_b, rt_b, rd_b, sh_b},
            {m_ir, m_valid, m_ill, m_src[25:6]});
        chk("w4_decode", {dec_b, imm_b[9:0]}, {m_dec, m_src[9:0]});
        chk("w4_jidx", 64'({imm_b, jidx_b}), 64'({m_src[15:0], m_src[25:0]}));
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check 1 time unit later.
    task automatic step(input logic r, input logic ii, input logic de, input logic ak,
                        input logic [31:0] w);
        logic [31:0] src;
        rst = r; ir_in = ii; decode_ena = de; ack = ak; instr_in = w;
        @(posedge clk);
        if (r) begin
            m_ir = '0; m_dec = '0; m_src = '0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = '0;
        end else begin
            src = ii ? w : m_ir;
            if (ii) m_ir = w;
            if (de) begin
                m_dec   = ref_decode(src);
                m_src   = src;
                m_ill   = (m_dec == '0);
                m_valid = 1'b1;
                if (!m_ill) m_cnt = m_cnt + 1;
            end else if (ak) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_word();
        int unsigned r;
        if ($urandom_range(3) != 0) begin
            r = $urandom_range(53);
            return rules[r].val | ($urandom & ~rules[r].mask);
        end
        return $urandom;
    endfunction

    initial begin
        build_rules();
        m_ir = '0; m_dec = '0; m_src = '0; m_valid = 1'b0; m_ill = 1'b0; m_cnt = '0;
        rst = 1'b1; ir_in = 1'b0; decode_ena = 1'b0; ack = 1'b0; instr_in = '0;

        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 32'h012A4020);
        chk("reset_dec", 64'(dec_a), 64'd0);
        chk("reset_cnt", 64'(cnt_a), 64'd0);
        chk("reset_valid", 64'(val_a), 64'd0);

        step(0, 1, 1, 0, 32'h012A4020);
        chk("add_ir", 64'(ir_a), 64'h012A4020);
        chk("add_dec", 64'(dec_a), 64'(onehot(0)));
        chk("add_fields", 64'({rs_a, rt_a, rd_a}), 64'({5'd9, 5'd10, 5'd8}));
        chk("add_valid", 64'(val_a), 64'd1);
        chk("add_cnt", 64'(cnt_a), 64'd1);

        step(0, 1, 1, 0, 32'h42000018);
        chk("eret", 64'(dec_a), 64'(onehot(33)));
        step(0, 1, 1, 0, 32'h70821020);
        chk("clz", 64'(dec_a), 64'(onehot(31)));
        step(0, 1, 1, 0, 32'h04210004);
        chk("bgez", 64'(dec_a), 64'(onehot(51)));
        chk("bgez_imm", 64'(imm_a), 64'h0004);
        step(0, 1, 1, 0, 32'h0C000010);
        chk("jal", 64'(dec_a), 64'(onehot(30)));
        chk("jal_jidx", 64'(jidx_a), 64'h10);

        step(0, 1, 1, 0, 32'hFC000000);
        chk("ill_dec", 64'(dec_a), 64'd0);
        chk("ill_flag", 64'(ill_a), 64'd1);
        chk("ill_valid", 64'(val_a), 64'd1);
        chk("ill_cnt", 64'(cnt_a), 64'd5);
        step(0, 1, 1, 0, 32'h3C010001);
        chk("lui", 64'(dec_a), 64'(onehot(28)));
        chk("lui_ill", 64'(ill_a), 64'd0);
        chk("lui_cnt", 64'(cnt_a), 64'd6);

        step(0, 0, 0, 1, 32'hFFFFFFFF);
        chk("ack_clears", 64'(val_a), 64'd0);
        step(0, 0, 0, 1, 32'hFFFFFFFF);
        chk("ack_empty_valid", 64'(val_a), 64'd0);
        chk("ack_empty_dec", 64'(dec_a), 64'(onehot(28)));
        step(0, 1, 1, 0, 32'h012A4020);
        step(0, 1, 1, 1, 32'h70821020);
        chk("ack_and_decode_valid", 64'(val_a), 64'd1);
        chk("ack_and_decode_dec", 64'(dec_a), 64'(onehot(31)));
        step(0, 0, 1, 0, 32'h3C010001);
        chk("decode_from_ir", 64'(dec_a), 64'(onehot(31)));

        for (int i = 0; i < 400; i++)
            step(($urandom_range(49) == 0), $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), rand_word());

        step(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 32'h3C010001);
        chk("wrap_w4", 64'(cnt_b), 64'd0);
        chk("wrap_main", 64'(cnt_a), 64'd16);
        step(1, 1, 1, 0, 32'h012A4020);
        chk("midrst_dec", 64'(dec_a), 64'd0);
        chk("midrst_ir", 64'(ir_a), 64'd0);
        chk("midrst_valid", 64'(val_a), 64'd0);
        chk("midrst_cnt", 64'(cnt_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
# instr_decoder

Registered MIPS instruction decoder that sits between instruction memory and the multicycle controller. It latches the fetched word into the instruction register and decodes it into the 54-bit one-hot `decoded_instr` vector the controller consumes. It also presents the register, immediate and jump fields. A valid/ack handshake tells the controller when a fresh decode is available. The block flags undefined encodings and keeps a retired-decode counter for debug.

## Interface
Parameters:
- `COUNT_W`, default 32: width of `instr_count`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `instr_in`, in, 32: fetched instruction word from instruction memory.
- `ir_in`, in, 1: latch `instr_in` into the IR.
- `decode_ena`, in, 1: decode the current instruction into the output registers.
- `ack`, in, 1: controller has consumed the current decode.
- `ir`, out, 32: instruction register contents.
- `decoded_instr`, out, 54: registered one-hot instruction class.
- `rs`, `rt`, `rd`, `shamt`, out, 5 each: registered fields, bits [25:21], [20:16], [15:11], [10:6].
- `imm16`, out, 16: registered bits [15:0].
- `jidx`, out, 26: registered bits [25:0].
- `dec_valid`, out, 1: a decode is held and not yet acked.
- `illegal`, out, 1: the held decode matched no supported encoding.
- `instr_count`, out, `COUNT_W`: number of legal decodes since reset.

## Operation
- **One-hot bit map** (bit:mnemonic), standard MIPS32 encodings:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu
  - 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr
  - 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne, 26 slti, 27 sltiu, 28 lui
  - 29 j, 30 jal, 31 clz, 32 divu, 33 eret, 34 jalr
  - 35 lb, 36 lbu, 37 lhu, 38 sb, 39 sh, 40 lh
  - 41 mfc0, 42 mfhi, 43 mflo, 44 mtc0, 45 mthi, 46 mtlo
  - 47 mul, 48 multu, 49 syscall, 50 teq, 51 bgez, 52 break, 53 div
- **Match rules:**
  - R-type (opcode 0x00): match on funct.
  - SPECIAL2 (opcode 0x1C): funct 0x20 is clz, 0x02 is mul.
  - COP0 (opcode 0x10): rs=0x00 is mfc0, rs=0x04 is mtc0; eret requires rs=0x10 and funct=0x18.
  - REGIMM (opcode 0x01): rt=0x01 is bgez.
  - Other fields are don't-care unless listed above.
- **Decode source:**
  - When `ir_in`=1, decode uses `instr_in` directly. This bypass lets fetch and decode share one controller state.
  - Otherwise decode uses `ir`.
- **IR:** loads `instr_in` on `ir_in`; holds otherwise.
- **Decode:** on `decode_ena`, the block registers `decoded_instr`, the fields and `illegal`, and sets `dec_valid`=1.
- **Illegal decode:** `decoded_instr`=0, `illegal`=1, `dec_valid`=1. Fields are still registered and `instr_count` is unchanged.
- **Legal decode:** exactly one bit of `decoded_instr` is set, `illegal`=0, and `instr_count` increments by 1. The counter wraps from all-ones to 0.
- **Handshake state machine:**
  - States: EMPTY (`dec_valid`=0) and HELD (`dec_valid`=1).
  - EMPTY goes to HELD on `decode_ena`.
  - HELD goes to EMPTY on `ack` without `decode_ena`.
  - HELD stays HELD on `decode_ena`, with new contents; this applies even when `ack` is also high (decode wins).
  - `ack` in EMPTY is ignored.
- While in EMPTY, `decoded_instr` and the fields keep their last values, but only `dec_valid` qualifies them.

## Timing
- **Reset:** `ir`=0, `decoded_instr`=0, all fields 0, `dec_valid`=0, `illegal`=0, `instr_count`=0.
- **Latency:**
  - `ir_in` at edge N: `ir` updates after edge N.
  - `decode_ena` at edge N: outputs valid after edge N, i.e. one-cycle decode latency.
  - `ir_in` and `decode_ena` together at edge N: both the IR and the decode reflect `instr_in` sampled at N.
- `ack` at edge N with `dec_valid`=1: `dec_valid`=0 after N.
- `rst` has priority over all inputs. If `rst` is asserted mid-decode, the pending decode is discarded and every output returns to its reset value at the next edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset:** drive 3 cycles with `ir_in`/`decode_ena` high and `rst`=1. All outputs stay 0 and `instr_count`=0.
- **Fused fetch and decode:** `instr_in`=0x012A4020 (add $t0,$t1,$t2) with `ir_in`=`decode_ena`=1 for one cycle. Next cycle: `ir`=0x012A4020, `decoded_instr`=bit0 only, `rs`=9, `rt`=10, `rd`=8, `dec_valid`=1, `instr_count`=1.
- **Multi-field sweep:**
  - 0x42000018 gives bit33 (eret).
  - 0x70821020 gives bit31 (clz).
  - 0x04210004 gives bit51 (bgez), `imm16`=0x0004.
  - 0x0C000010 gives bit30 (jal), `jidx`=0x10.
- **Illegal encoding:** 0xFC000000 gives `decoded_instr`=0, `illegal`=1, `dec_valid`=1, `instr_count` unchanged. Then 0x3C010001 (lui) gives bit28 and `illegal`=0.
- **Handshake:**
  - `ack` with `dec_valid`=1: `dec_valid` goes to 0.
  - `ack` and `decode_ena` together: `dec_valid` stays 1 with the new decode.
  - `ack` while EMPTY: no change.
- **Counter wrap and mid-operation reset:** with `COUNT_W`=4, do 16 legal decodes; `instr_count` returns to 0. Assert `rst` in the same cycle as `decode_ena`; all outputs are 0 next cycle.
